// File: rtl/fir_pkg.sv
// Shared widths, FSM state type, PIO response layout and the Q1.15 coefficient ROM
// for the PIO-driven FIR sequencer.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 36;
  localparam int CNT_W    = 13;
  localparam int PIO_W    = 31;
  localparam int PROD_W   = 2 * SAMPLE_W;
  localparam int MAX_TAPS = 16;
  localparam int TAP_W    = 4;

  // Bit positions inside the processor request word.
  localparam int REQ_TGL  = 30;
  localparam int REQ_CLR  = 29;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    MAC,
    ROUND,
    DONE
  } state_t;

  // Field order matches the pio_rsp word from bit 30 down to bit 0.
  typedef struct packed {
    logic                ack;
    logic                ovr;
    logic [CNT_W-1:0]    cnt;
    logic [SAMPLE_W-1:0] res;
  } rsp_t;

  // Taps 0..7 stay at or below 0.5 so a full-scale impulse reproduces them exactly.
  localparam logic signed [SAMPLE_W-1:0] COEF [0:MAX_TAPS-1] = '{
    16'sd2048,  16'sd4096,  16'sd8192,  16'sd16384,
    16'sd16384, 16'sd8192,  16'sd4096,  16'sd2048,
    16'sd1024,  -16'sd512,  -16'sd1024, 16'sd512,
    16'sd256,   -16'sd256,  16'sd128,   -16'sd128
  };

endpackage

// File: rtl/fir_mac_datapath.sv
// Delay line, one shared multiplier, 36-bit accumulator and round/reduce stage.
// FIR_SATURATE_EN clamps the rounded result to 16 bits; otherwise the low 16 bits are kept.
module fir_mac_datapath
  import fir_pkg::*;
#(
  parameter int N_TAPS    = 8,
  parameter int COEF_FRAC = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       shift,
  input  logic                       clear,
  input  logic                       acc_en,
  input  logic                       round_en,
  input  logic [TAP_W-1:0]           tap,
  output logic signed [SAMPLE_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC - 1);

  logic signed [SAMPLE_W-1:0] delay [0:MAX_TAPS-1];
  logic signed [PROD_W-1:0]   tap_x;
  logic signed [PROD_W-1:0]   coef_x;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    rounded;
  logic signed [SAMPLE_W-1:0] reduced;

  // Slots at or above N_TAPS are never written and read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_TAPS; i++) delay[i] <= '0;
    end else if (shift) begin
      delay[0] <= sample;
      for (int i = 1; i < N_TAPS; i++) delay[i] <= delay[i-1];
    end
  end

  assign tap_x  = PROD_W'(delay[tap]);
  assign coef_x = PROD_W'(COEF[tap]);
  assign prod   = tap_x * coef_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign rounded = (acc + RND) >>> COEF_FRAC;

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

  always_comb begin
    reduced = rounded[SAMPLE_W-1:0];
    if (rounded > SAT_MAX) begin
      reduced = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (rounded < SAT_MIN) begin
      reduced = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end
  end
`else
  logic unused_hi;

  assign reduced   = rounded[SAMPLE_W-1:0];
  assign unused_hi = ^rounded[ACC_W-1:SAMPLE_W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (round_en) begin
      result <= reduced;
    end
  end

endmodule

// File: rtl/fir_pio_sequencer.sv
// Toggle-handshake PIO front end for a time-multiplexed FIR; ack lands N_TAPS+3 cycles after detection.
// Define FIR_SATURATE_EN to clamp results instead of wrapping them to 16 bits.
module fir_pio_sequencer
  import fir_pkg::*;
#(
  parameter int N_TAPS    = 8,
  parameter int COEF_FRAC = 15
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [PIO_W-1:0] pio_req,
  output logic [PIO_W-1:0] pio_rsp,
  output logic             busy
);

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic                       req_q;
  logic                       req_seen;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic [TAP_W-1:0]           tap;
  rsp_t                       rsp_q;
  logic signed [SAMPLE_W-1:0] dp_result;
  logic                       dp_shift;
  logic                       dp_clear;
  logic                       dp_acc;
  logic                       dp_round;
  logic                       unused_req;

  assign req_seen   = pio_req[REQ_TGL] ^ req_q;
  assign unused_req = ^pio_req[28:16];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dp_shift  = 1'b0;
    dp_clear  = 1'b0;
    dp_acc    = 1'b0;
    dp_round  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_seen) state_nxt = SHIFT;
      end
      SHIFT: begin
        dp_shift  = 1'b1;
        dp_clear  = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        dp_acc = 1'b1;
        if (tap == LAST_TAP) state_nxt = ROUND;
      end
      ROUND: begin
        dp_round  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A toggle seen outside IDLE is dropped and flagged; a same-cycle clear loses to it.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      req_q    <= 1'b0;
      sample_q <= '0;
      tap      <= '0;
      rsp_q    <= '0;
    end else begin
      req_q <= pio_req[REQ_TGL];
      if (state == IDLE && req_seen) sample_q <= pio_req[SAMPLE_W-1:0];

      if (dp_shift) begin
        tap <= '0;
      end else if (dp_acc) begin
        tap <= tap + TAP_W'(1);
      end

      if (req_seen && state != IDLE) begin
        rsp_q.ovr <= 1'b1;
      end else if (pio_req[REQ_CLR]) begin
        rsp_q.ovr <= 1'b0;
      end

      if (state == DONE) begin
        rsp_q.ack <= req_q;
        rsp_q.cnt <= rsp_q.cnt + CNT_W'(1);
        rsp_q.res <= dp_result;
      end
    end
  end

  assign pio_rsp = rsp_q;
  assign busy    = (state != IDLE);

  fir_mac_datapath #(
    .N_TAPS    (N_TAPS),
    .COEF_FRAC (COEF_FRAC)
  ) u_datapath (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .sample   (sample_q),
    .shift    (dp_shift),
    .clear    (dp_clear),
    .acc_en   (dp_acc),
    .round_en (dp_round),
    .tap      (tap),
    .result   (dp_result)
  );

  tap_in_range: assert property (
    @(posedge clk_clk) disable iff (reset_reset) (state == MAC) |-> (tap <= LAST_TAP)
  );

endmodule

// File: tb/tb_fir_pio_sequencer.sv
// Directed bench: reset, latency/busy, impulse, overrun and clear, saturation or wrap,
// reset in the middle of MAC, and 13-bit count wrap on a 2-tap instance.
module tb_fir_pio_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [30:0] pio_req  = '0;
  logic [30:0] pio_req2 = '0;
  logic [30:0] pio_rsp;
  logic [30:0] pio_rsp2;
  logic        busy;
  logic        busy2;
  logic        tgl  = 1'b0;
  logic        tgl2 = 1'b0;
  logic [12:0] exp_cnt = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef FIR_SATURATE_EN
  localparam logic [15:0] EXP_SAT5 = 16'h7FFF;
  localparam logic [15:0] EXP_FULL = 16'h7FFF;
`else
  localparam logic [15:0] EXP_SAT5 = 16'hB8F9;
  localparam logic [15:0] EXP_FULL = 16'hEFFE;
`endif

  always #5 clk = ~clk;

  fir_pio_sequencer #(.N_TAPS(8), .COEF_FRAC(15)) u_dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .pio_req     (pio_req),
    .pio_rsp     (pio_rsp),
    .busy        (busy)
  );

  fir_pio_sequencer #(.N_TAPS(2), .COEF_FRAC(15)) u_dut2 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .pio_req     (pio_req2),
    .pio_rsp     (pio_rsp2),
    .busy        (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    tgl = ~tgl;
    pio_req[15:0] = s;
    pio_req[30]   = tgl;
  endtask

  task automatic wait_count(input logic [12:0] target);
    int c;
    c = 0;
    while (pio_rsp[28:16] !== target && c < 40) begin
      tick();
      c++;
    end
  endtask

  task automatic run_req(input string tag, input logic [15:0] s, input bit do_res,
                         input logic [15:0] exp_res);
    send(s);
    exp_cnt = exp_cnt + 13'd1;
    wait_count(exp_cnt);
    chk({tag, "_cnt"}, 32'(pio_rsp[28:16]), 32'(exp_cnt));
    if (do_res) chk({tag, "_res"}, 32'(pio_rsp[15:0]), 32'(exp_res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] imp [0:7];
    int cyc;
    int busy_n;
    int to;
    int c;

    imp = '{16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h4000, 16'h2000, 16'h1000, 16'h0800};

    // Reset state
    repeat (3) tick();
    chk("rst_rsp", 32'(pio_rsp), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // Latency and busy width on the impulse's first sample
    send(16'h7FFF);
    exp_cnt = 13'd1;
    tick();
    busy_n = busy ? 1 : 0;
    cyc = 0;
    while (pio_rsp[30] !== tgl && cyc < 40) begin
      tick();
      cyc++;
      if (busy) busy_n++;
    end
    chk("lat_cycles", 32'(cyc), 32'd11);
    chk("lat_busy", 32'(busy_n), 32'd11);
    chk("imp0_word", 32'(pio_rsp), 32'({1'b1, 1'b0, 13'd1, 16'h0800}));

    // Impulse tail: successive results walk through the coefficients, then zero
    for (int k = 1; k < 8; k++) run_req($sformatf("imp%0d", k), 16'h0000, 1'b1, imp[k]);
    run_req("imp_tail", 16'h0000, 1'b1, 16'h0000);
    chk("imp_ack", 32'(pio_rsp[30]), 32'(tgl));

    // Overrun: second toggle two cycles into the first sample
    send(16'd100);
    tick();
    tick();
    send(16'd999);
    exp_cnt = exp_cnt + 13'd1;
    wait_count(exp_cnt);
    chk("ovr_cnt", 32'(pio_rsp[28:16]), 32'(exp_cnt));
    chk("ovr_res", 32'(pio_rsp[15:0]), 32'd6);
    chk("ovr_flag", 32'(pio_rsp[29]), 32'd1);
    chk("ovr_ack", 32'(pio_rsp[30]), 32'(tgl));
    repeat (15) tick();
    chk("ovr_single_ack", 32'(pio_rsp[28:16]), 32'(exp_cnt));
    chk("ovr_sticky", 32'(pio_rsp[29]), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd0);
    pio_req[29] = 1'b1;
    tick();
    pio_req[29] = 1'b0;
    chk("ovr_clear", 32'(pio_rsp[29]), 32'd0);

    // Set and clear in the same cycle: set wins
    send(16'd0);
    tick();
    pio_req[29] = 1'b1;
    send(16'd0);
    tick();
    pio_req[29] = 1'b0;
    exp_cnt = exp_cnt + 13'd1;
    wait_count(exp_cnt);
    chk("setwin_cnt", 32'(pio_rsp[28:16]), 32'(exp_cnt));
    chk("setwin_res", 32'(pio_rsp[15:0]), 32'd13);
    chk("setwin_flag", 32'(pio_rsp[29]), 32'd1);
    pio_req[29] = 1'b1;
    tick();
    pio_req[29] = 1'b0;
    chk("setwin_clear", 32'(pio_rsp[29]), 32'd0);

    // Reset in MAC cycle 3, then a request already pending at reset release
    send(16'h7FFF);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_rsp", 32'(pio_rsp), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    tgl = 1'b1;
    pio_req = {1'b1, 1'b0, 13'd0, 16'd1000};
    tick();
    rst = 1'b0;
    exp_cnt = 13'd1;
    wait_count(exp_cnt);
    chk("postrst_word", 32'(pio_rsp), 32'({1'b1, 1'b0, 13'd1, 16'd63}));

    // Repeated full scale: partial sums, then the full-window saturate/wrap result
    for (int k = 1; k <= 9; k++) begin
      if (k == 4)      run_req("sat4", 16'h7FFF, 1'b1, 16'h79F3);
      else if (k == 5) run_req("sat5", 16'h7FFF, 1'b1, EXP_SAT5);
      else if (k >= 8) run_req($sformatf("sat%0d", k), 16'h7FFF, 1'b1, EXP_FULL);
      else             run_req("satfill", 16'h7FFF, 1'b0, 16'h0000);
    end

    // Count wrap on the 2-tap instance
    to = 0;
    for (int i = 1; i <= 8193; i++) begin
      tgl2 = ~tgl2;
      pio_req2[30] = tgl2;
      tick();
      c = 0;
      while (pio_rsp2[30] !== tgl2 && c < 20) begin
        tick();
        c++;
      end
      if (c >= 20) to++;
      if (i == 1) begin
        chk("n2_latency", 32'(c), 32'd5);
        chk("n2_busy_idle", 32'(busy2), 32'd0);
      end
      if (i == 8191) chk("cnt_8191", 32'(pio_rsp2[28:16]), 32'd8191);
      if (i == 8192) chk("cnt_wrap0", 32'(pio_rsp2[28:16]), 32'd0);
    end
    chk("cnt_wrap1", 32'(pio_rsp2[28:16]), 32'd1);
    chk("n2_timeouts", 32'(to), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_pio_sequencer.md
FIR_PIO_SEQUENCER -- requirements
Module: fir_pio_sequencer

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, number of active taps (legal range 2..16).
REQ-002 SHALL have parameter COEF_FRAC, default 15, fractional bits of the coefficients and the result shift.
REQ-003 SHALL have port clk_clk, input, 1 bit: the only clock; all logic rising-edge.
REQ-004 SHALL have port reset_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port pio_req, input, 31 bits: word from processor PIO:
- [30] request toggle
- [29] clear-overrun level
- [15:0] signed sample
- [28:16] ignored
REQ-006 SHALL have port pio_rsp, output, 31 bits: word to processor PIO:
- [30] ack toggle
- [29] overrun sticky
- [28:16] processed-sample count
- [15:0] signed filter result
REQ-007 SHALL have port busy, output, 1 bit: high while a sample is in flight.

Function
REQ-008 SHALL register pio_req[30] into req_q each cycle; a request is detected when pio_req[30] != req_q.
REQ-009 SHALL use FSM states IDLE, SHIFT, MAC, ROUND, DONE.
REQ-010 SHALL leave IDLE for SHIFT on a detected request and capture pio_req[15:0] in that same cycle.
REQ-011 SHALL, in SHIFT, shift the captured sample into delay-line slot 0 (oldest slot discarded) and clear the accumulator.
REQ-012 SHALL, in MAC, add one product per cycle (delay[k] * COEF[k], k = 0..N_TAPS-1) into a 36-bit signed accumulator, using exactly N_TAPS cycles and one multiplier.
REQ-013 SHALL, in ROUND, add 2^(COEF_FRAC-1), arithmetic-shift right by COEF_FRAC, then reduce the value to 16 bits per REQ-022/023.
REQ-014 SHALL, in DONE, in one cycle:
- write the result to pio_rsp[15:0]
- increment the count, wrapping 8191 -> 0
- set pio_rsp[30] equal to req_q
- return to IDLE
REQ-015 SHALL update pio_rsp[15:0], [28:16] and [30] together on the same edge, so the processor never reads a torn word.
REQ-016 SHALL flip pio_rsp[30] exactly N_TAPS+3 cycles after the edge that detected the request.
REQ-017 SHALL hold busy high in states SHIFT, MAC, ROUND and DONE, and low in IDLE.
REQ-018 SHALL, for a request detected while not in IDLE: drop the request, set overrun pio_rsp[29], update req_q, and leave the in-flight computation unaffected.
REQ-019 SHALL clear overrun on any cycle with pio_req[29]=1; when a set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-020 SHALL, on reset_reset assertion, immediately force:
- FSM to IDLE
- all delay-line entries, the accumulator, the count and req_q to 0
- pio_rsp to 31'h0 and busy to 0
An in-flight sample SHALL be discarded without an ack.
REQ-021 SHALL sample pio_req as usual on the first edge after reset release; if pio_req[30]=1 at that edge, a request SHALL be detected.

Configuration
REQ-022 SHALL, with macro FIR_SATURATE_EN defined, clamp the ROUND result to [-32768, 32767].
REQ-023 SHALL, with FIR_SATURATE_EN undefined, take the ROUND result as its low 16 bits (two's-complement wrap); all other behaviour SHALL be identical.

Structure
REQ-024 SHALL place the following in package fir_pkg:
- state enum
- SAMPLE_W=16, ACC_W=36, CNT_W=13
- constant COEF[0:15] of signed 16-bit Q1.15 coefficients
REQ-025 SHALL split into the FSM/PIO logic plus one sub-module fir_mac_datapath (delay line, multiplier, accumulator, round/reduce), controlled by shift/clear/acc/tap-index strobes.

Verification
REQ-026 SHALL cover impulse: sample 32767 then N_TAPS zeros -> successive results ≈ COEF[0..N_TAPS-1] scaled, within ±1 LSB.
REQ-027 SHALL cover latency: toggle pio_req[30] -> pio_rsp[30] flips exactly N_TAPS+3 cycles later, busy high for N_TAPS+3 cycles.
REQ-028 SHALL cover overrun: second toggle 2 cycles after the first -> one ack only, pio_rsp[29]=1, count +1; then pio_req[29]=1 -> pio_rsp[29]=0.
REQ-029 SHALL cover saturation: repeated 32767 with all COEF=16384 -> result 32767 with FIR_SATURATE_EN, wrapped low 16 bits without.
REQ-030 SHALL cover reset mid-MAC: reset asserted in cycle 3 of MAC -> pio_rsp=0 and busy=0 immediately; next request computes from an all-zero delay line.
REQ-031 SHALL cover count wrap: 8193 requests -> count reads 1.
